// File: rtl/debounce_pkg.sv
// Shared state encoding for input-conditioning blocks.
// Two-bit debounce FSM states.
package debounce_pkg;

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Resets both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizer, debounce FSM and stability counter.
// Produces a clean level plus one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
  output logic rise,
  output logic fall
);

  import debounce_pkg::*;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             din_sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (din_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (din_sync) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!din_sync) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!din_sync) begin
            state <= WAIT_LOW;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (din_sync) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with STABLE_CYCLES=4.
// Expected strobes and levels are queued by stimulus, checked by monitor.
module tb_switch_debouncer;

  typedef struct {
    int cyc;
    int kind;
    bit val;
  } lvl_t;

  typedef struct {
    int cyc;
    bit is_rise;
  } stb_t;

  logic clk = 1'b0;
  logic rst;
  logic din_raw;
  logic dout;
  logic rise;
  logic fall;
  logic dff_q;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  lvl_t lq[$];
  stb_t sq[$];

  switch_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_raw (din_raw),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream D flip-flop fed by dout
  always @(posedge clk) dff_q <= dout;

  task automatic exp_lvl(input int c, input int k, input bit v);
    lvl_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    lq.push_back(e);
  endtask

  task automatic exp_stb(input int c, input bit r);
    stb_t e;
    e.cyc = c;
    e.is_rise = r;
    sq.push_back(e);
  endtask

  // apply inputs so they are sampled at edge n
  task automatic drive(input int n, input bit r, input bit d);
    while (cyc != n - 1) @(negedge clk);
    rst = r;
    din_raw = d;
  endtask

  always @(negedge clk) begin
    bit got;
    logic act;
    lvl_t l;
    stb_t s;
    if (rise && fall) begin
      tests++;
      fails++;
      $display("FAIL both_strobes cyc=%0d rise=%b fall=%b required not both",
               cyc, rise, fall);
    end
    if (rise || fall) begin
      tests++;
      if (sq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe cyc=%0d rise=%b fall=%b required none",
                 cyc, rise, fall);
      end else begin
        s = sq.pop_front();
        got = rise;
        if (s.cyc != cyc || got != s.is_rise) begin
          fails++;
          $display("FAIL strobe cyc=%0d rise=%b fall=%b required cyc=%0d rise=%b",
                   cyc, rise, fall, s.cyc, s.is_rise);
        end
      end
    end
    while (lq.size() != 0 && lq[0].cyc <= cyc) begin
      l = lq.pop_front();
      act = (l.kind == 0) ? dout : dff_q;
      tests++;
      if (l.cyc != cyc || act !== l.val) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%b required=%b at cyc=%0d",
                 (l.kind == 0) ? "dout" : "dff_q", cyc, act, l.val, l.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    din_raw = 1'b1;
    // reset held over edges 1..3 with din_raw high
    exp_lvl(1, 0, 1'b0);
    exp_lvl(2, 0, 1'b0);
    exp_lvl(3, 0, 1'b0);
    drive(4, 1'b0, 1'b0);

    // clean rise: commit 5 edges after input settles
    exp_lvl(14, 0, 1'b0);
    exp_lvl(15, 0, 1'b1);
    exp_lvl(15, 1, 1'b0);
    exp_lvl(16, 1, 1'b1);
    exp_stb(15, 1'b1);
    drive(10, 1'b0, 1'b1);

    // clean fall
    exp_lvl(24, 0, 1'b1);
    exp_lvl(25, 0, 1'b0);
    exp_stb(25, 1'b0);
    drive(20, 1'b0, 1'b0);

    // bounce 1,0,1,0 then hold 1 from edge 34
    exp_lvl(35, 0, 1'b0);
    exp_lvl(38, 0, 1'b0);
    exp_lvl(39, 0, 1'b1);
    exp_stb(39, 1'b1);
    drive(30, 1'b0, 1'b1);
    drive(31, 1'b0, 1'b0);
    drive(32, 1'b0, 1'b1);
    drive(33, 1'b0, 1'b0);
    drive(34, 1'b0, 1'b1);

    // glitch low for 3 samples: rejected
    exp_lvl(49, 0, 1'b1);
    exp_lvl(50, 0, 1'b1);
    exp_lvl(52, 0, 1'b1);
    drive(45, 1'b0, 1'b0);
    drive(48, 1'b0, 1'b1);

    // clean fall
    exp_lvl(64, 0, 1'b1);
    exp_lvl(65, 0, 1'b0);
    exp_stb(65, 1'b0);
    drive(60, 1'b0, 1'b0);

    // reset at edge 74 during WAIT_HIGH restarts qualification
    exp_lvl(74, 0, 1'b0);
    exp_lvl(79, 0, 1'b0);
    exp_lvl(80, 0, 1'b1);
    exp_stb(80, 1'b1);
    drive(70, 1'b0, 1'b1);
    drive(74, 1'b1, 1'b1);
    drive(75, 1'b0, 1'b1);

    // fall, then a rise whose commit edge 105 coincides with reset
    exp_lvl(94, 0, 1'b1);
    exp_lvl(95, 0, 1'b0);
    exp_stb(95, 1'b0);
    drive(90, 1'b0, 1'b0);
    exp_lvl(105, 0, 1'b0);
    exp_lvl(110, 0, 1'b0);
    exp_lvl(111, 0, 1'b1);
    exp_stb(111, 1'b1);
    drive(100, 1'b0, 1'b1);
    drive(105, 1'b1, 1'b1);
    drive(106, 1'b0, 1'b1);

    while (cyc < 125) @(negedge clk);
    #1;
    tests++;
    if (sq.size() != 0 || lq.size() != 0) begin
      fails++;
      $display("FAIL leftover strobes=%0d levels=%0d required 0",
               sq.size(), lq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
